// File: rtl/pipe_buf_reg.sv
// Elastic pipeline buffer register: valid/ready payload stage with optional
// 2-entry skid, flush-to-bubble and a saturating stall counter.
module pipe_buf_reg #(
  parameter int unsigned      WIDTH      = 41,
  parameter bit               SKID       = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter int unsigned      CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic acc;
  logic load;

  // Without skid the ready path is combinational from downstream; with skid
  // it is fully registered and the spare entry absorbs the extra beat.
  assign in_ready = SKID ? in_ready_q : (out_ready | ~out_valid_q);
  assign acc      = in_valid & in_ready;
  assign load     = ~out_valid_q | out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      out_data_d   = BUBBLE_VAL;
    end else if (load) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = acc;
        if (acc) skid_data_d = in_data;
      end else begin
        out_valid_d = acc;
        if (acc) out_data_d = in_data;
      end
    end else if (acc) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid_q & ~out_ready & (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= BUBBLE_VAL;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
      stall_cnt_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign stall_cnt = stall_cnt_q;
  assign occupancy = {out_valid_q & skid_valid_q,
                      out_valid_q ^ skid_valid_q};

endmodule

// File: tb/tb_pipe_buf_reg.sv
// Bench for pipe_buf_reg: three instances (skid, no-skid, 4-bit counter)
// checked against a FIFO-level model every cycle plus directed literals.
module tb_pipe_buf_reg;

  localparam logic [40:0] BUB = 41'h13;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        iv[3];
  logic [40:0] id[3];
  logic        ordy[3];
  logic        fl[3];
  logic        clr[3];

  logic        ovo[3];
  logic [40:0] odo[3];
  logic        iro[3];
  logic [1:0]  occo[3];
  logic [15:0] sco0, sco1;
  logic [3:0]  sco2;

  pipe_buf_reg #(.WIDTH(41), .SKID(1'b1), .BUBBLE_VAL(BUB), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset),
    .in_valid(iv[0]), .in_data(id[0]), .in_ready(iro[0]),
    .out_valid(ovo[0]), .out_data(odo[0]), .out_ready(ordy[0]),
    .flush(fl[0]), .occupancy(occo[0]), .stall_cnt(sco0),
    .stall_clr(clr[0]));

  pipe_buf_reg #(.WIDTH(41), .SKID(1'b0), .BUBBLE_VAL(BUB), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset),
    .in_valid(iv[1]), .in_data(id[1]), .in_ready(iro[1]),
    .out_valid(ovo[1]), .out_data(odo[1]), .out_ready(ordy[1]),
    .flush(fl[1]), .occupancy(occo[1]), .stall_cnt(sco1),
    .stall_clr(clr[1]));

  pipe_buf_reg #(.WIDTH(41), .SKID(1'b1), .BUBBLE_VAL(BUB), .CNT_W(4)) u2 (
    .clk(clk), .reset(reset),
    .in_valid(iv[2]), .in_data(id[2]), .in_ready(iro[2]),
    .out_valid(ovo[2]), .out_data(odo[2]), .out_ready(ordy[2]),
    .flush(fl[2]), .occupancy(occo[2]), .stall_cnt(sco2),
    .stall_clr(clr[2]));

  int checks = 0;
  int errors = 0;

  // Model: ordered list of held entries, last shown payload, stall count.
  logic [40:0] me[3][2];
  int          mn[3];
  logic [40:0] mhold[3];
  int          mcnt[3];
  bit          mheld[3];

  function automatic int cap(int i);
    return (i == 1) ? 1 : 2;
  endfunction

  function automatic int sat(int i);
    return (i == 2) ? 15 : 65535;
  endfunction

  function automatic logic exp_ir(int i);
    if (i == 1) return (mn[i] == 0) || ordy[i];
    return mn[i] < 2;
  endfunction

  function automatic logic [15:0] dut_sc(int i);
    case (i)
      0: return sco0;
      1: return sco1;
      default: return {12'd0, sco2};
    endcase
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", nm, i, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mn[i] = 0;
      mhold[i] = BUB;
      mcnt[i] = 0;
      mheld[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      logic ov, rdy, pop, push;
      ov   = mn[i] > 0;
      rdy  = exp_ir(i);
      pop  = ov && ordy[i];
      push = iv[i] && rdy;
      if (clr[i]) mcnt[i] = 0;
      else if (ov && !ordy[i] && mcnt[i] < sat(i)) mcnt[i]++;
      mheld[i] = iv[i] && !rdy && !fl[i];
      if (fl[i]) begin
        mn[i] = 0;
        mhold[i] = BUB;
      end else begin
        if (pop) begin
          me[i][0] = me[i][1];
          mn[i]--;
        end
        if (push && mn[i] < cap(i)) begin
          me[i][mn[i]] = id[i];
          mn[i]++;
        end
        if (mn[i] > 0) mhold[i] = me[i][0];
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk("out_valid", i, 64'(ovo[i]), 64'(mn[i] > 0));
      chk("out_data", i, 64'(odo[i]), 64'(mhold[i]));
      chk("in_ready", i, 64'(iro[i]), 64'(exp_ir(i)));
      chk("occupancy", i, 64'(occo[i]), 64'(mn[i]));
      chk("stall_cnt", i, 64'(dut_sc(i)), 64'(mcnt[i]));
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      id[i] = '0;
      ordy[i] = 1'b1;
      fl[i] = 1'b0;
      clr[i] = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    model_reset();
    @(posedge clk);
    #1;
    settle();
    chk("rst_ov", 0, 64'(ovo[0]), 64'd0);
    chk("rst_od", 0, 64'(odo[0]), 64'h13);
    chk("rst_occ", 0, 64'(occo[0]), 64'd0);
    chk("rst_sc", 0, 64'(sco0), 64'd0);
    #1 reset = 1'b0;
    tick();

    // streaming
    iv[0] = 1; id[0] = 41'h001; ordy[0] = 1;
    settle(); tick();
    id[0] = 41'h002;
    settle();
    chk("stream1", 0, 64'(odo[0]), 64'h001);
    chk("stream_occ", 0, 64'(occo[0]), 64'd1);
    tick();
    id[0] = 41'h003;
    settle();
    chk("stream2", 0, 64'(odo[0]), 64'h002);
    tick();
    iv[0] = 0;
    settle();
    chk("stream3", 0, 64'(odo[0]), 64'h003);
    chk("stream_ov", 0, 64'(ovo[0]), 64'd1);
    tick();
    settle();
    chk("drain_ov", 0, 64'(ovo[0]), 64'd0);
    chk("drain_hold", 0, 64'(odo[0]), 64'h003);
    tick();

    // backpressure
    iv[0] = 1; id[0] = 41'hAAA; ordy[0] = 1; clr[0] = 1;
    settle(); tick();
    id[0] = 41'hBBB; ordy[0] = 0; clr[0] = 0;
    settle();
    chk("bp_ir0", 0, 64'(iro[0]), 64'd1);
    tick();
    id[0] = 41'hCCC;
    settle();
    chk("bp_occ", 0, 64'(occo[0]), 64'd2);
    chk("bp_ir", 0, 64'(iro[0]), 64'd0);
    chk("bp_od", 0, 64'(odo[0]), 64'hAAA);
    tick();
    settle(); tick();
    ordy[0] = 1;
    settle();
    chk("bp_sc", 0, 64'(sco0), 64'd3);
    chk("bp_hold", 0, 64'(odo[0]), 64'hAAA);
    tick();
    settle();
    chk("bp_ord2", 0, 64'(odo[0]), 64'hBBB);
    chk("bp_ir1", 0, 64'(iro[0]), 64'd1);
    tick();
    iv[0] = 0;
    settle();
    chk("bp_ord3", 0, 64'(odo[0]), 64'hCCC);
    tick();
    settle(); tick();

    // flush at occupancy 2
    iv[0] = 1; id[0] = 41'h111; ordy[0] = 0;
    settle(); tick();
    id[0] = 41'h222;
    settle(); tick();
    id[0] = 41'hDDD; fl[0] = 1;
    settle();
    chk("fl_occ2", 0, 64'(occo[0]), 64'd2);
    tick();
    fl[0] = 0; iv[0] = 0; ordy[0] = 1;
    settle();
    chk("fl_ov", 0, 64'(ovo[0]), 64'd0);
    chk("fl_od", 0, 64'(odo[0]), 64'h13);
    chk("fl_occ", 0, 64'(occo[0]), 64'd0);
    chk("fl_ir", 0, 64'(iro[0]), 64'd1);
    tick();
    settle();
    chk("fl_noddd", 0, 64'(ovo[0]), 64'd0);
    tick();

    // no-skid combinational ready
    iv[1] = 1; id[1] = 41'h077; ordy[1] = 0;
    settle(); tick();
    id[1] = 41'h123;
    settle();
    chk("ns_ir0", 1, 64'(iro[1]), 64'd0);
    #1 ordy[1] = 1;
    #1 chk("ns_ir1", 1, 64'(iro[1]), 64'd1);
    tick();
    iv[1] = 0;
    settle();
    chk("ns_od", 1, 64'(odo[1]), 64'h123);
    tick();

    // saturating stall counter
    iv[2] = 1; id[2] = 41'h005; ordy[2] = 1;
    settle(); tick();
    iv[2] = 0; ordy[2] = 0;
    repeat (20) begin settle(); tick(); end
    settle();
    chk("sat", 2, 64'(sco2), 64'd15);
    clr[2] = 1;
    tick();
    clr[2] = 0;
    settle();
    chk("clr", 2, 64'(sco2), 64'd0);
    tick();
    settle();
    chk("resume", 2, 64'(sco2), 64'd1);
    tick();
    ordy[2] = 1;

    // async reset mid-stall
    iv[0] = 1; id[0] = 41'h111; ordy[0] = 0;
    settle(); tick();
    id[0] = 41'h222;
    settle(); tick();
    iv[0] = 0;
    settle();
    chk("ar_occ2", 0, 64'(occo[0]), 64'd2);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("ar_ov", 0, 64'(ovo[0]), 64'd0);
    chk("ar_occ", 0, 64'(occo[0]), 64'd0);
    chk("ar_od", 0, 64'(odo[0]), 64'h13);
    chk("ar_sc", 0, 64'(sco0), 64'd0);
    #1 reset = 1'b0;
    idle_all();
    iv[0] = 1; id[0] = 41'h055;
    tick();
    iv[0] = 0;
    settle();
    chk("ar_first", 0, 64'(odo[0]), 64'h055);
    chk("ar_first_ov", 0, 64'(ovo[0]), 64'd1);
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        logic [63:0] r;
        if (!mheld[i]) begin
          r = {$urandom(), $urandom()};
          iv[i] = ($urandom_range(0, 3) != 0);
          id[i] = r[40:0];
        end
        ordy[i] = ($urandom_range(0, 9) < 6);
        fl[i]   = ($urandom_range(0, 31) == 0);
        clr[i]  = ($urandom_range(0, 63) == 0);
      end
      settle();
      tick();
    end
    idle_all();
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_buf_reg.md
Name: pipe_buf_reg

Overview:
- Generic elastic pipeline buffer register for the 5-stage core; replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB buffer registers with one parametrised instance per stage.
- Carries an opaque packed payload between stages with valid/ready handshake, optional 2-entry skid buffering, synchronous flush with bubble injection, and a saturating stall counter for performance debug.
- Sits between two pipeline stages. The upstream stage drives in_*. The downstream stage consumes out_*.

Parameters:
- WIDTH, 41, payload width in bits (41 = IF/ID: 9-bit PC + 32-bit instruction).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- BUBBLE_VAL, '0, value loaded into out_data on reset and flush. The IF/ID instance uses the NOP encoding 32'h00000013 in its instruction field.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  stage clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream payload valid.
- in_data  input  WIDTH  upstream payload.
- in_ready  output  1  buffer can accept this cycle.
- out_valid  output  1  downstream payload valid.
- out_data  output  WIDTH  downstream payload, registered.
- out_ready  input  1  downstream accepts this cycle (deasserted = stall).
- flush  input  1  synchronous kill of all held entries (branch mispredict / jump).
- occupancy  output  2  entries held, 0..2 (max 1 when SKID=0).
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- stall_clr  input  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=BUBBLE_VAL, skid entry invalid, occupancy=0, stall_cnt=0. in_ready=1 once reset is deasserted.
- Transfer in: in_valid & in_ready at an edge. Transfer out: out_valid & out_ready at an edge. Latency through an empty buffer is 1 cycle.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - On accept, out_data <= in_data and out_valid <= 1.
  - On drain without accept, out_valid <= 0. out_data holds its last value.
- SKID=1:
  - in_ready is a register equal to ~skid_valid. It has no combinational path from out_ready.
  - Main register loads when (~out_valid | out_ready). Source is the skid entry if valid, else in_data.
  - If the main register cannot load and an input is accepted, the input goes to the skid entry and skid_valid <= 1.
  - When the main register loads from skid and a new input arrives in the same cycle, the new input goes into skid. Order is preserved: skid data always leaves before newer data.
  - Full state (occupancy=2): in_ready=0. Upstream must hold in_data/in_valid stable.
- Simultaneous in/out transfer at occupancy 1 keeps occupancy 1 with new data. No bubble, full throughput of 1 per cycle.
- flush=1 at an edge:
  - out_valid <= 0, skid_valid <= 0, out_data <= BUBBLE_VAL, occupancy <= 0.
  - Any input accepted in the same cycle is discarded.
  - An out transfer in that cycle still counts as delivered to downstream.
  - in_ready=1 next cycle.
  - Flush has priority over every other update except reset.
- Payload is never modified except by BUBBLE_VAL substitution. out_data is stable while out_valid=1 and out_ready=0.
- stall_cnt:
  - Increments by 1 on each edge with out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - stall_clr has priority over increment. stall_cnt is unaffected by flush.
- Reset asserted mid-transfer drops all entries with no partial state. The first post-reset input behaves as into an empty buffer.

Test Plan:
- Streaming, SKID=1, out_ready=1, in_data = 0x001, 0x002, 0x003 on consecutive cycles -> out_data shows 0x001, 0x002, 0x003 one cycle later, out_valid continuous, occupancy stays 1.
- Backpressure: accept 0xAAA, drop out_ready for 3 cycles while offering 0xBBB then 0xCCC -> 0xBBB goes into skid, in_ready=0 from the next cycle, 0xCCC is held upstream, out_data stays 0xAAA, stall_cnt=3. On out_ready=1, the output order is 0xAAA, 0xBBB, 0xCCC.
- Flush with occupancy=2 and in_valid=1 (0xDDD) -> next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy=0, in_ready=1, and 0xDDD never appears.
- SKID=0 instance, out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. Raising out_ready with in_valid=1 (0x123) -> in_ready=1 combinationally, out_data=0x123 next edge.
- Stall counter, CNT_W=4: hold a stall for 20 cycles -> stall_cnt saturates at 15. stall_clr asserted during the stall -> 0 next edge, then resumes incrementing.
- Async reset asserted mid-stall at occupancy=2 -> outputs go to reset values immediately without a clock edge. After deassert, a single input 0x055 appears 1 cycle later.
